// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, NOP encoding, reset PC and word alignment.
package mips_pkg;

  localparam int          MIPS_INSTR_W  = 32;
  localparam logic [31:0] MIPS_NOP      = 32'h0000_0000;
  localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mips_fetch_skid.sv
// One-entry skid buffer holding a fetched instruction and its PC+4 while decode is stalled.
module mips_fetch_skid
  import mips_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_load,
  input  logic                    i_unload,
  input  logic                    i_clear,
  input  logic [MIPS_INSTR_W-1:0] i_instr,
  input  logic [31:0]             i_pc4,
  output logic                    o_valid,
  output logic [MIPS_INSTR_W-1:0] o_instr,
  output logic [31:0]             o_pc4
);

  logic                    r_valid;
  logic [MIPS_INSTR_W-1:0] r_instr;
  logic [31:0]             r_pc4;

  // Entry storage; clear wins so a redirect can never leave a stale word behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_instr <= MIPS_NOP;
      r_pc4   <= 32'h0000_0000;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem handshake, skid buffer and IF/ID register.
// Optional MIPS_FETCH_PERF_EN adds fetched/stall/flush performance counters.
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = MIPS_RESET_PC
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic                    imem_ready,
  input  logic [MIPS_INSTR_W-1:0] imem_rdata,
  input  logic                    stall_f,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic [MIPS_INSTR_W-1:0] instr_d,
  output logic [31:0]             pc_plus4_d,
  output logic                    valid_d
`ifdef MIPS_FETCH_PERF_EN
  ,
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_stall_cycles,
  output logic [31:0]             perf_flushes
`endif
);

  fetch_state_e            r_state, w_state_nxt;
  logic [31:0]             r_pc, r_tgt, r_pc4;
  logic [MIPS_INSTR_W-1:0] r_instr;
  logic                    r_valid, r_req;

  logic [31:0]             w_pc_nxt, w_tgt_nxt, w_pc_plus4, w_redir_pc, w_ifid_pc4;
  logic [MIPS_INSTR_W-1:0] w_ifid_instr, w_skid_instr;
  logic [31:0]             w_skid_pc4;
  logic                    w_ifid_load, w_ifid_clr, w_accept;
  logic                    w_skid_load, w_skid_unload, w_skid_clear, w_skid_valid;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redir_pc = word_align(redirect_pc);
  assign w_accept   = r_req & imem_ready;

  mips_fetch_skid u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (w_skid_clear),
    .i_instr  (imem_rdata),
    .i_pc4    (w_pc_plus4),
    .o_valid  (w_skid_valid),
    .o_instr  (w_skid_instr),
    .o_pc4    (w_skid_pc4)
  );

  // Next-state, PC and IF/ID control; redirect outranks stall and any response.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_tgt_nxt     = r_tgt;
    w_ifid_load   = 1'b0;
    w_ifid_clr    = 1'b0;
    w_ifid_instr  = imem_rdata;
    w_ifid_pc4    = w_pc_plus4;
    w_skid_load   = 1'b0;
    w_skid_unload = 1'b0;
    w_skid_clear  = 1'b0;
    case (r_state)
      FETCH: begin
        if (redirect) begin
          w_ifid_clr   = 1'b1;
          w_skid_clear = 1'b1;
          if (r_req && !imem_ready) begin
            // Memory still owes a response on the old address: park the target.
            w_tgt_nxt   = w_redir_pc;
            w_state_nxt = DRAIN;
          end else begin
            w_pc_nxt = w_redir_pc;
          end
        end else if (w_accept) begin
          w_pc_nxt = w_pc_plus4;
          if (stall_f) begin
            w_skid_load = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_ifid_load = 1'b1;
          end
        end else if (!stall_f) begin
          w_ifid_clr = 1'b1;
        end else begin
          w_ifid_clr = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_ifid_clr   = 1'b1;
          w_skid_clear = 1'b1;
          w_pc_nxt     = w_redir_pc;
          w_state_nxt  = FETCH;
        end else if (!stall_f) begin
          w_ifid_load   = w_skid_valid;
          w_ifid_instr  = w_skid_instr;
          w_ifid_pc4    = w_skid_pc4;
          w_skid_unload = 1'b1;
          w_state_nxt   = FETCH;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      DRAIN: begin
        w_ifid_clr = 1'b1;
        if (redirect) begin
          w_tgt_nxt = w_redir_pc;
          if (imem_ready) begin
            w_pc_nxt    = w_redir_pc;
            w_state_nxt = FETCH;
          end else begin
            w_state_nxt = DRAIN;
          end
        end else if (imem_ready) begin
          w_pc_nxt    = r_tgt;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  // FSM, PC and request register; request stays low during reset and while holding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_tgt   <= RESET_PC;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
      r_req   <= (w_state_nxt != HOLD);
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr <= MIPS_NOP;
      r_pc4   <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else if (w_ifid_clr) begin
      r_instr <= MIPS_NOP;
      r_valid <= 1'b0;
    end else if (w_ifid_load) begin
      r_instr <= w_ifid_instr;
      r_pc4   <= w_ifid_pc4;
      r_valid <= 1'b1;
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign instr_d    = r_instr;
  assign pc_plus4_d = r_pc4;
  assign valid_d    = r_valid;

`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_stall, r_perf_flush;

  // Free-running event counters, wrapping on overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_fetched <= 32'd0;
      r_perf_stall   <= 32'd0;
      r_perf_flush   <= 32'd0;
    end else begin
      r_perf_fetched <= r_perf_fetched + {31'd0, (w_ifid_load & ~w_ifid_clr)};
      r_perf_stall   <= r_perf_stall + {31'd0, stall_f};
      r_perf_flush   <= r_perf_flush + {31'd0, redirect};
    end
  end

  assign perf_fetched      = r_perf_fetched;
  assign perf_stall_cycles = r_perf_stall;
  assign perf_flushes      = r_perf_flush;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Randomized self-checking bench for mips_fetch_stage against an instruction-stream reference model.
module tb_mips_fetch_stage;
  import mips_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_f;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall_cycles, perf_flushes;
`endif

  always #5 clk = ~clk;

  mips_fetch_stage #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall_f     (stall_f),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_d     (instr_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d)
`ifdef MIPS_FETCH_PERF_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc4;
  } ent_t;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: next fetch address, pending redirect target, buffered words, IF/ID view.
  logic [31:0] m_pc, m_tgt, m_instr, m_pc4;
  bit          m_valid, m_req, m_drain;
  ent_t        m_skid[$];
  logic [31:0] m_fetched, m_stalls, m_flushes;

  // Memory responder: word = address after a per-request latency.
  int mem_cnt, mem_lat, g_lat;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_lat();
    return (g_lat < 0) ? int'($urandom_range(0, 2)) : g_lat;
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_tgt = RPC; m_instr = 32'd0; m_pc4 = 32'd0;
    m_valid = 1'b0; m_req = 1'b0; m_drain = 1'b0;
    m_skid.delete();
    m_fetched = 32'd0; m_stalls = 32'd0; m_flushes = 32'd0;
    mem_cnt = 0; mem_lat = pick_lat();
  endtask

  task automatic check_outputs();
    check_val("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    check_val("imem_addr", imem_addr, m_pc);
    check_val("valid_d", {31'd0, valid_d}, {31'd0, m_valid});
    if (m_valid) begin
      check_val("instr_d", instr_d, m_instr);
      check_val("pc_plus4_d", pc_plus4_d, m_pc4);
    end
`ifdef MIPS_FETCH_PERF_EN
    check_val("perf_fetched", perf_fetched, m_fetched);
    check_val("perf_stall", perf_stall_cycles, m_stalls);
    check_val("perf_flushes", perf_flushes, m_flushes);
`endif
  endtask

  // One clock: check at negedge, drive inputs, advance the model, move to next negedge.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    logic [31:0] a;
    ent_t e;
    check_outputs();
    stall_f = st; redirect = rd; redirect_pc = rpc;
    if (imem_req && mem_cnt >= mem_lat) begin
      imem_ready = 1'b1; imem_rdata = imem_addr;
    end else begin
      imem_ready = 1'b0; imem_rdata = $urandom;
    end
    a = rpc & 32'hFFFF_FFFC;
    if (st) m_stalls++;
    if (rd) m_flushes++;
    if (m_skid.size() != 0) begin
      if (rd) begin
        m_valid = 1'b0; m_skid.delete(); m_pc = a;
      end else if (!st) begin
        e = m_skid.pop_front();
        m_instr = e.word; m_pc4 = e.pc4; m_valid = 1'b1; m_fetched++;
      end
    end else if (m_drain) begin
      m_valid = 1'b0;
      if (rd) m_tgt = a;
      if (imem_ready) begin m_pc = m_tgt; m_drain = 1'b0; end
    end else if (rd) begin
      m_valid = 1'b0;
      if (m_req && !imem_ready) begin m_drain = 1'b1; m_tgt = a; end
      else m_pc = a;
    end else if (m_req && imem_ready) begin
      e.word = imem_rdata; e.pc4 = m_pc + 32'd4;
      if (st) m_skid.push_back(e);
      else begin m_instr = e.word; m_pc4 = e.pc4; m_valid = 1'b1; m_fetched++; end
      m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_valid = 1'b0;
    end
    m_req = (m_skid.size() == 0);
    if (imem_ready) begin mem_cnt = 0; mem_lat = pick_lat(); end
    else if (imem_req) mem_cnt++;
    else mem_cnt = 0;
    @(negedge clk);
  endtask

  // Asynchronous reset: outputs must take reset values before any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b0; stall_f = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
    #1;
    check_val("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check_val("rst_imem_addr", imem_addr, RPC);
    check_val("rst_instr_d", instr_d, MIPS_NOP);
    check_val("rst_pc_plus4_d", pc_plus4_d, 32'd0);
    check_val("rst_valid_d", {31'd0, valid_d}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; stall_f = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_ready = 1'b0; imem_rdata = 32'd0;
    g_lat = 0;
    @(negedge clk);
    do_reset();

    // Zero-wait streaming
    repeat (6) step(1'b0, 1'b0, 32'd0);
    // Three-cycle stall, then resume
    repeat (3) step(1'b1, 1'b0, 32'd0);
    repeat (4) step(1'b0, 1'b0, 32'd0);
    // Redirect in FETCH
    step(1'b0, 1'b1, 32'h40);
    repeat (4) step(1'b0, 1'b0, 32'd0);
    // Two-cycle latency with redirect in the first wait cycle
    g_lat = 2;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 32'd0);
      if (imem_ready) break;
    end
    check_val("lat2_resp_seen", {31'd0, imem_ready}, 32'd1);
    step(1'b0, 1'b1, 32'h80);
    repeat (8) step(1'b0, 1'b0, 32'd0);
    // Redirect and stall together with unaligned target
    g_lat = 0;
    repeat (3) step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h43);
    repeat (4) step(1'b0, 1'b0, 32'd0);
    // PC wrap-around
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (5) step(1'b0, 1'b0, 32'd0);
    // Reset while holding
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'd0);
      if (m_skid.size() != 0) break;
    end
    step(1'b1, 1'b0, 32'd0);
    do_reset();
    repeat (4) step(1'b0, 1'b0, 32'd0);

    // Randomized traffic
    g_lat = -1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), $urandom);
      end
    end
    check_outputs();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_fetch_stage.md
# mips_fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the PC, issues requests to instruction memory, and loads the IF/ID pipeline register that feeds the decode stage of `MIPS_PIPELINE_TOP`. Supports variable-latency memory, a single-entry skid buffer for decode stalls, and branch/jump redirects from decode that squash in-flight fetches.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `imem_req`  out  1  fetch request; address held stable until `imem_ready`.
- `imem_addr`  out  32  fetch address, equal to the PC register.
- `imem_ready`  in  1  response valid this cycle; may be high in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word, valid when `imem_ready`.
- `stall_f`  in  1  hazard-unit stall: hold IF/ID contents.
- `redirect`  in  1  taken branch or jump from decode.
- `redirect_pc`  in  32  redirect target; bits [1:0] forced to 0.
- `instr_d`  out  32  IF/ID instruction.
- `pc_plus4_d`  out  32  IF/ID PC+4 of `instr_d`.
- `valid_d`  out  1  IF/ID holds a real instruction; 0 means bubble.

## Operation
- FSM states: FETCH, HOLD, DRAIN. Reset state FETCH.
- FETCH: `imem_req`=1. On `imem_ready` with `stall_f`=0, IF/ID loads {`imem_rdata`, PC+4, valid=1} and PC advances by 4. On `imem_ready` with `stall_f`=1, the word goes to the skid buffer, PC advances by 4, and the FSM moves to HOLD. With no `imem_ready` and `stall_f`=0, `valid_d` is 0 next cycle (bubble). With no `imem_ready` and `stall_f`=1, IF/ID holds.
- HOLD: `imem_req`=0. When `stall_f` drops, IF/ID loads from the skid buffer and the FSM returns to FETCH. No instruction is lost or duplicated.
- Redirect has priority over stall and over any response:
  - PC loads `redirect_pc & ~3`, `valid_d` is cleared next cycle, and the skid buffer is emptied.
  - In FETCH with `imem_ready` high, or in HOLD: go to FETCH. The response is discarded.
  - In FETCH with a request outstanding and `imem_ready` low: go to DRAIN.
- DRAIN: `imem_req` stays high on the old address. On `imem_ready` the response is discarded and the FSM goes to FETCH at the redirect PC. A new redirect in DRAIN updates the PC and stays in DRAIN.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values, applied immediately and asynchronously:
  - `imem_req`=0 while in reset, 1 from the first clock after release.
  - `imem_addr`=`RESET_PC`.
  - `instr_d`=0, `pc_plus4_d`=0, `valid_d`=0.
  - Skid buffer empty.
- All outputs are registered or decoded directly from state/PC, with no combinational path from `imem_rdata` to outputs. There is a combinational path from `imem_ready` to nothing except next-state logic.
- Latency: IF/ID valid one clock edge after the accepting `imem_ready`. Throughput is 1 instruction/cycle with zero-wait memory.
- Reset asserted mid-operation (any state) returns to the reset values; an outstanding memory request is abandoned.

## Configuration
- `MIPS_FETCH_PERF_EN` defined: adds 32-bit outputs `perf_fetched`, `perf_stall_cycles` and `perf_flushes`.
  - `perf_fetched` counts IF/ID loads with valid=1.
  - `perf_stall_cycles` counts cycles with `stall_f`=1.
  - `perf_flushes` counts redirects.
  - All three reset to 0 and wrap on overflow.
- Not defined: these ports and counters do not exist.

## Structure
- Shared package `mips_pkg`: fetch-state enum (FETCH/HOLD/DRAIN), `MIPS_NOP` constant (32'h0000_0000), default reset PC, instruction width constant.
- One sub-module: `mips_fetch_skid`, a one-entry buffer with load, unload and clear, holding the instruction word and PC+4.

## Test plan
- Zero-wait memory returning word = address: after reset release, `valid_d` rises on the second edge with `instr_d`=0, `pc_plus4_d`=4, then 4/8, 8/12, … every cycle.
- `stall_f` high for 3 cycles while `imem_ready`=1: HOLD is entered, `imem_req`=0, and IF/ID is unchanged. After release the sequence continues with no gap or duplicate (e.g. 0x10 then 0x14).
- Redirect to 32'h40 in FETCH: next cycle `valid_d`=0, then `instr_d`=0x40 with `pc_plus4_d`=0x44.
- 2-cycle memory latency, redirect to 32'h80 in the first wait cycle: FSM goes to DRAIN, the stale response is never loaded into IF/ID, and the next `imem_addr` is 0x80.
- Redirect and `stall_f` in the same cycle with `redirect_pc`=32'h43: IF/ID is flushed (`valid_d`=0) and fetch resumes at 0x40.
- `reset` driven low mid-HOLD: `valid_d`=0, `instr_d`=0, `imem_req`=0 and `imem_addr`=`RESET_PC` immediately, before the next clock edge.
